// File: rtl/rom_fetch_unit_if.sv
// rom_fetch_unit_if: bus bundle between the fetch unit, the program ROM and
// the instruction decoder. All vectors are numbered with bit 0 as the MSB.
//   addr     : ROM address (fetch unit -> ROM)
//   enrom    : ROM enable, high on fetch cycles (fetch unit -> ROM)
//   data     : ROM read data, combinational from addr (ROM -> fetch unit)
//   ir       : head-of-queue instruction (fetch unit -> decoder)
//   ir_pc    : address ir was fetched from (fetch unit -> decoder)
//   ir_valid : ir holds a real instruction (fetch unit -> decoder)
//   ir_ready : decoder takes ir this cycle (decoder -> fetch unit)
// master = fetch unit side, slave = ROM/decoder side.
interface rom_fetch_unit_if #(
  parameter int AW = 8,
  parameter int DW = 13
);
  logic [0:AW-1] addr;
  logic          enrom;
  logic [0:DW-1] data;
  logic [0:DW-1] ir;
  logic [0:AW-1] ir_pc;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    output addr, enrom, ir, ir_pc, ir_valid,
    input  data, ir_ready
  );

  modport slave (
    input  addr, enrom, ir, ir_pc, ir_valid,
    output data, ir_ready
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: instruction fetch sequencer. Owns the program counter,
// reads the program ROM one word per fetch cycle into a small prefetch
// queue and presents the queue head to the decoder over valid/ready.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : pulse, IDLE/HALTED -> RUN
//   halt       : pulse, stop fetching and go HALTED
//   jmp        : load pc from jmp_addr and flush the queue
//   jmp_addr   : jump target (bit 0 = MSB)
//   pc         : next fetch address
//   busy       : high while in RUN
//   wrapped    : sticky, pc has rolled over from the top address
//   bus        : ROM + decoder bundle (rom_fetch_unit_if.master)
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | out of reset, waiting for start
// RUN     | fetching whenever the queue has room
// HALTED  | fetching stopped, queue drains, start resumes at pc
module rom_fetch_unit #(
  parameter int AW       = 8,
  parameter int DW       = 13,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0,
  parameter int WRAP     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          jmp,
  input  logic [0:AW-1] jmp_addr,
  output logic [0:AW-1] pc,
  output logic          busy,
  output logic          wrapped,
  rom_fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [0:AW-1] RESET_PC_C = AW'(RESET_PC);
  localparam logic [0:AW-1] PC_MAX     = {AW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [0:DW-1] q_data [DEPTH];
  logic [0:AW-1] q_pc   [DEPTH];
  logic          fetch, pop, last, ir_valid;

  assign last     = (pc == PC_MAX);
  assign ir_valid = (count != '0);
  // A jump discards the queue, so a handshake in the jump cycle is dropped.
  assign pop      = ir_valid && bus.ir_ready && !jmp;

  always_comb begin
    state_nxt = state;
    fetch     = (state == S_RUN) && (count < DEPTH_C) && !jmp && !halt;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (halt || (WRAP == 0 && fetch && last)) state_nxt = S_HALTED;
      S_HALTED: if (start) state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC_C;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      wrapped <= 1'b0;
    end else if (jmp) begin
      pc     <= jmp_addr;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (fetch) begin
        pc     <= pc + AW'(1);
        wr_ptr <= wr_ptr + PW'(1);
        if (last) wrapped <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({fetch, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: every read is gated by ir_valid.
  always_ff @(posedge clk) begin
    if (fetch) begin
      q_data[wr_ptr] <= bus.data;
      q_pc[wr_ptr]   <= pc;
    end
  end

  assign bus.addr     = pc;
  assign bus.enrom    = fetch;
  assign bus.ir_valid = ir_valid;
  assign bus.ir       = ir_valid ? q_data[rd_ptr] : '0;
  assign bus.ir_pc    = ir_valid ? q_pc[rd_ptr]   : '0;
  assign busy         = (state == S_RUN);

endmodule
